pdm_decoder: RTL and testbench
==============================

Name: pdm_decoder

Overview:
- Receive side of the board's 1-bit pulse-density interface. It is the inverse of the `pdm` encoder that drives the LED matrix.
- Takes a PDM bitstream from a breakout pin or from an on-chip `pdm` loopback and recovers a multi-bit sample.
- Uses a 2nd-order CIC (sinc²) decimator with saturation and a one-cycle output strobe.
- Output width matches the encoder's 10-bit `din`, so an encoder→decoder loopback is self-checking.

Parameters:
- DEC_LOG2, 5, decimation ratio R = 2^DEC_LOG2 accepted input bits per output sample.
- WIDTH, 10, output sample width. Constraint: 1 ≤ WIDTH ≤ 2·DEC_LOG2.

Ports:
- clk  in  1  system clock (48 MHz HFOSC domain).
- rst  in  1  synchronous, active-high reset.
- din  in  1  PDM bit; sampled only when din_valid=1.
- din_valid  in  1  input sample enable. Tie to 1 for one bit per clk.
- dout  out  WIDTH  decoded sample; held between strobes.
- dout_valid  out  1  one-cycle strobe, high when dout updates.
- sat  out  1  registered with dout; 1 if the current dout was clipped.

Behaviour:
- Interface fixed: one clock `clk`; reset `rst` is synchronous and active-high.
- Reset: on any posedge with rst=1, all of the following clear to 0:
  - int1, int2, comb delay registers c1d and c2d
  - sample counter cnt
  - settle counter
  - dout, dout_valid, sat
- rst overrides din_valid. Reset mid-frame discards the partial frame, and the settle suppression restarts.
- Accumulator width ACC_W = 2·DEC_LOG2+1. All integrator and comb arithmetic is unsigned modulo 2^ACC_W. Wrap is intentional and must not be saturated.
- Accepted sample (din_valid=1, rst=0):
  - int1 <= int1 + din
  - int2 <= int2 + int1 (old int1; pipelined form)
  - cnt <= cnt+1, wrapping at R-1→0
- din_valid=0: int1, int2 and cnt hold.
- Decimation tick: registered flag `tick` <= 1 on the accepting edge where cnt==R-1, else 0.
- Comb stage, on the edge where tick==1:
  - c1 = int2 − c1d; c1d <= int2
  - c2 = c1 − c2d; c2d <= c1
  - y = c2 >> (2·DEC_LOG2 − WIDTH)
  - dout <= min(y, 2^WIDTH−1); sat <= (y > 2^WIDTH−1)
  - dout_valid <= 1 if settle count ≥ 2, else 0; settle saturates at 2.
- Settle: the first 2 comb outputs after reset are filter fill and are suppressed. dout_valid stays 0 for them, but dout and sat still update.
- dout_valid is 0 on every edge where tick==0, so it is strictly a single-cycle pulse.
- Latency: dout_valid is high in the cycle after the second clk edge following the R-th accepted bit of a frame.
- Frame to frame with din_valid=1 continuously: dout_valid period is exactly R clocks.
- Gain:
  - DC gain R², so all-ones input yields y = 2^WIDTH and saturates to 2^WIDTH−1 with sat=1.
  - For a constant-density input with steady state reached, dout = density·2^WIDTH, exact for periodic patterns whose period divides R.
- Simultaneous events: tick and an accepted bit on the same edge are independent; both updates occur.

Decomposition:
- Shared package `pdm_pkg`:
  - PDM_WIDTH = 10, shared with the `pdm` encoder din width.
  - Default DEC_LOG2 = 5.
  - Function acc_width(dec_log2) = 2·dec_log2+1.
- One sub-module is natural: `pdm_cic_stage`, a parameterised integrator/comb pair.
  - Ports: clk, rst, en_int, en_comb, in, out; width ACC_W.
  - pdm_decoder instantiates it twice and adds the counter, settle logic, shift and saturation.

Test Plan:
- Reset, then din=0, din_valid=1 for 10 frames (320 clk) → dout_valid pulses every 32 clk starting with the 3rd frame; dout=0, sat=0.
- din=1 constant, 5 frames → from the 3rd frame, dout=1023, sat=1, one pulse per 32 clk; no pulse in frames 1–2.
- din alternating 1,0,1,0…, 6 frames → settled dout=512 every strobe, sat=0. Pattern 1,0,0,0 repeating → dout=256.
- din_valid toggled 1/0 every clk with the alternating pattern → strobe period is 64 clk and dout is still 512. Bits presented while din_valid=0 have no effect: inverting them changes nothing.
- rst pulsed for one cycle at cnt=17 in frame 4 → next clk all outputs are 0. The next 2 frames give no dout_valid, and the 3rd post-reset frame strobes dout=512.
- Loopback: `pdm` encoder with din=300, rst=0, driving din with din_valid=1, 20 frames → every settled strobe has dout within 300±2, sat=0.

Source files
------------

// File: rtl/pdm_decoder_pkg.sv
// rtl/pdm_decoder_pkg.sv - shared constants and helpers for the PDM encoder/decoder pair
//
// PDM_WIDTH    : sample width shared with the pdm encoder din
// PDM_DEC_LOG2 : default log2 of the decimation ratio
// acc_width()  : CIC accumulator width for a given decimation log2
package pdm_pkg;

    localparam int PDM_WIDTH    = 10;
    localparam int PDM_DEC_LOG2 = 5;

    // A 2nd-order CIC grows by 2*log2(R) bits; one extra bit keeps
    // the all-ones result (exactly R^2) representable before clipping.
    function automatic int acc_width(input int dec_log2);
        return 2 * dec_log2 + 1;
    endfunction

endpackage

// File: rtl/pdm_decoder_if.sv
// rtl/pdm_decoder_if.sv - PDM bit input and decoded sample output bundle
//
// din, din_valid          : PDM bit and its sample enable (source -> decoder)
// dout, dout_valid, sat   : decoded sample, one-cycle strobe, clip flag (decoder -> sink)
// modport master          : the side that drives PDM bits and reads samples
// modport slave           : the decoder side
interface pdm_decoder_if
    import pdm_pkg::*;
#(
    parameter int WIDTH = PDM_WIDTH
);

    logic             din;
    logic             din_valid;
    logic [WIDTH-1:0] dout;
    logic             dout_valid;
    logic             sat;

    modport master (
        output din,
        output din_valid,
        input  dout,
        input  dout_valid,
        input  sat
    );

    modport slave (
        input  din,
        input  din_valid,
        output dout,
        output dout_valid,
        output sat
    );

endinterface

// File: rtl/pdm_cic_stage.sv
// rtl/pdm_cic_stage.sv - one CIC integrator plus one CIC comb, modulo 2^ACC_W
//
// clk, rst  : clock, synchronous active-high reset
// en_int    : integrator update enable (accepted input sample)
// en_comb   : comb delay update enable (decimation tick)
// in / out  : integrator input / registered integrator value
// comb_in   : comb input (decimated-rate signal)
// comb_out  : comb_in minus the previous decimated comb_in
module pdm_cic_stage #(
    parameter int ACC_W = 11
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en_int,
    input  logic             en_comb,
    input  logic [ACC_W-1:0] in,
    output logic [ACC_W-1:0] out,
    input  logic [ACC_W-1:0] comb_in,
    output logic [ACC_W-1:0] comb_out
);

    logic [ACC_W-1:0] acc_q;
    logic [ACC_W-1:0] dly_q;

    // Wrap-around in both registers is intentional: the comb
    // difference recovers the exact result as long as the true value
    // fits in ACC_W bits.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= '0;
            dly_q <= '0;
        end else begin
            if (en_int) begin
                acc_q <= acc_q + in;
            end
            if (en_comb) begin
                dly_q <= comb_in;
            end
        end
    end

    assign out      = acc_q;
    assign comb_out = comb_in - dly_q;

endmodule

// File: rtl/pdm_decoder.sv
// rtl/pdm_decoder.sv - sinc^2 CIC decimator turning a PDM bitstream into WIDTH-bit samples
//
// clk  : system clock
// rst  : synchronous active-high reset
// bus  : pdm_decoder_if.slave
//        din/din_valid       PDM bit, accepted when din_valid=1
//        dout                decoded sample, held between strobes
//        dout_valid          one-cycle strobe when dout updates (after 2 fill frames)
//        sat                 dout was clipped to 2^WIDTH-1
module pdm_decoder
    import pdm_pkg::*;
#(
    parameter int DEC_LOG2 = PDM_DEC_LOG2,
    parameter int WIDTH    = PDM_WIDTH
) (
    input  logic          clk,
    input  logic          rst,
    pdm_decoder_if.slave  bus
);

    localparam int ACC_W = acc_width(DEC_LOG2);
    localparam int SHIFT = 2 * DEC_LOG2 - WIDTH;
    localparam logic [ACC_W-1:0] DOUT_MAX = ACC_W'((1 << WIDTH) - 1);

    logic                accept;
    logic [DEC_LOG2-1:0] cnt_q;
    logic                tick_q;
    logic [1:0]          settle_q;
    logic [WIDTH-1:0]    dout_q;
    logic                dout_valid_q;
    logic                sat_q;

    logic [ACC_W-1:0]    din_ext;
    logic [ACC_W-1:0]    int1;
    logic [ACC_W-1:0]    int2;
    logic [ACC_W-1:0]    c1;
    logic [ACC_W-1:0]    c2;
    logic [ACC_W-1:0]    y;
    logic                clip;

    assign accept  = bus.din_valid;
    assign din_ext = {{(ACC_W-1){1'b0}}, bus.din};

    // Stage 1 owns int1 and the first comb (applied to int2);
    // stage 2 owns int2 (fed by the old int1) and the second comb.
    pdm_cic_stage #(.ACC_W(ACC_W)) u_stage1 (
        .clk      (clk),
        .rst      (rst),
        .en_int   (accept),
        .en_comb  (tick_q),
        .in       (din_ext),
        .out      (int1),
        .comb_in  (int2),
        .comb_out (c1)
    );

    pdm_cic_stage #(.ACC_W(ACC_W)) u_stage2 (
        .clk      (clk),
        .rst      (rst),
        .en_int   (accept),
        .en_comb  (tick_q),
        .in       (int1),
        .out      (int2),
        .comb_in  (c1),
        .comb_out (c2)
    );

    assign y    = c2 >> SHIFT;
    assign clip = (y > DOUT_MAX);

    // cnt is exactly DEC_LOG2 bits wide, so it wraps R-1 -> 0 by itself.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            tick_q <= accept && (cnt_q == '1);
            if (accept) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    // The first two comb outputs after reset still carry filter fill,
    // so they update dout/sat but are not announced.
    always_ff @(posedge clk) begin
        if (rst) begin
            settle_q     <= 2'd0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            sat_q        <= 1'b0;
        end else if (tick_q) begin
            dout_q       <= clip ? DOUT_MAX[WIDTH-1:0] : y[WIDTH-1:0];
            sat_q        <= clip;
            dout_valid_q <= settle_q[1];
            if (!settle_q[1]) begin
                settle_q <= settle_q + 2'd1;
            end
        end else begin
            dout_valid_q <= 1'b0;
        end
    end

    assign bus.dout       = dout_q;
    assign bus.dout_valid = dout_valid_q;
    assign bus.sat        = sat_q;

endmodule

// File: tb/tb_pdm_decoder.sv
// tb/tb_pdm_decoder.sv - directed scoreboard bench for pdm_decoder
module tb_pdm_decoder;
    import pdm_pkg::*;

    localparam int R = 1 << PDM_DEC_LOG2;

    localparam int PAT_ZERO = 0;
    localparam int PAT_ONE  = 1;
    localparam int PAT_ALT  = 2;
    localparam int PAT_1000 = 3;
    localparam int PAT_LOOP = 4;

    typedef struct {
        int dout;
        int sat;
        bit tol;
    } exp_t;

    logic clk = 1'b0;
    logic rst;

    pdm_decoder_if #(.WIDTH(PDM_WIDTH)) bus ();

    pdm_decoder #(
        .DEC_LOG2 (PDM_DEC_LOG2),
        .WIDTH    (PDM_WIDTH)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    exp_t sb[$];
    int   n_vec       = 0;
    int   n_err       = 0;
    int   cyc         = 0;
    int   last_strobe = -1;
    int   period      = R;
    exp_t mon_e;
    int   mon_d;

    always @(posedge clk) cyc++;

    task automatic check(input string tag, input int obs, input int exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step(input logic b, input logic v);
        bus.din       = b;
        bus.din_valid = v;
        @(negedge clk);
    endtask

    task automatic drain();
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0);
    endtask

    task automatic do_reset();
        rst           = 1'b1;
        bus.din       = 1'b0;
        bus.din_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst         = 1'b0;
        last_strobe = -1;
    endtask

    function automatic logic pat_bit(input int pat, input int k);
        case (pat)
            PAT_ONE:  return 1'b1;
            PAT_ALT:  return (k % 2) == 0;
            PAT_1000: return (k % 4) == 0;
            default:  return 1'b0;
        endcase
    endfunction

    // Drives whole frames after a reset; frames 1-2 are fill, so an
    // expected sample is queued for every frame from the 3rd on.
    task automatic run(input int frames, input int pat, input int exp_dout,
                       input int exp_sat, input bit tol, input bit half_rate);
        exp_t       e;
        logic [9:0] enc_acc = '0;
        logic [10:0] enc_sum;
        logic       b;
        int         k = 0;
        for (int f = 1; f <= frames; f++) begin
            if (f >= 3) begin
                e.dout = exp_dout;
                e.sat  = exp_sat;
                e.tol  = tol;
                sb.push_back(e);
            end
            for (int i = 0; i < R; i++) begin
                if (pat == PAT_LOOP) begin
                    // first-order sigma-delta, same as the pdm encoder with din=300
                    enc_sum = {1'b0, enc_acc} + 11'd300;
                    enc_acc = enc_sum[9:0];
                    b       = enc_sum[10];
                end else begin
                    b = pat_bit(pat, k);
                end
                k++;
                if (half_rate) begin
                    step(b, 1'b1);
                    step(~b, 1'b0);
                end else begin
                    step(b, 1'b1);
                end
            end
        end
    endtask

    always @(negedge clk) begin
        if (bus.dout_valid === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_strobe_cycle", cyc, -1);
            end else begin
                mon_e = sb.pop_front();
                mon_d = int'(bus.dout);
                if (mon_e.tol) begin
                    check("loop_dout_pm2",
                          (mon_d >= mon_e.dout - 2 && mon_d <= mon_e.dout + 2) ? mon_e.dout : mon_d,
                          mon_e.dout);
                end else begin
                    check("dout", mon_d, mon_e.dout);
                end
                check("sat", int'(bus.sat), mon_e.sat);
            end
            if (last_strobe >= 0) check("strobe_period", cyc - last_strobe, period);
            last_strobe = cyc;
        end
    end

    initial begin
        rst           = 1'b1;
        bus.din       = 1'b0;
        bus.din_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_dout", int'(bus.dout), 0);
        check("rst_dout_valid", int'(bus.dout_valid), 0);
        check("rst_sat", int'(bus.sat), 0);
        rst = 1'b0;

        period = R;
        run(10, PAT_ZERO, 0, 0, 1'b0, 1'b0);
        drain();
        check("sb_empty_zero", sb.size(), 0);

        do_reset();
        run(5, PAT_ONE, 1023, 1, 1'b0, 1'b0);
        drain();
        check("sb_empty_ones", sb.size(), 0);

        do_reset();
        run(6, PAT_ALT, 512, 0, 1'b0, 1'b0);
        drain();
        check("sb_empty_alt", sb.size(), 0);

        do_reset();
        run(6, PAT_1000, 256, 0, 1'b0, 1'b0);
        drain();
        check("sb_empty_1000", sb.size(), 0);

        do_reset();
        period = 2 * R;
        run(6, PAT_ALT, 512, 0, 1'b0, 1'b1);
        drain();
        check("sb_empty_half_rate", sb.size(), 0);

        // reset mid-frame: three frames, then 17 bits into frame 4
        do_reset();
        period = R;
        run(3, PAT_ALT, 512, 0, 1'b0, 1'b0);
        for (int i = 0; i < 17; i++) step(pat_bit(PAT_ALT, i), 1'b1);
        check("pre_rst_dout", int'(bus.dout), 512);
        check("sb_empty_pre_rst", sb.size(), 0);
        rst           = 1'b1;
        bus.din       = 1'b1;
        bus.din_valid = 1'b1;
        @(negedge clk);
        check("midrst_dout", int'(bus.dout), 0);
        check("midrst_dout_valid", int'(bus.dout_valid), 0);
        check("midrst_sat", int'(bus.sat), 0);
        rst         = 1'b0;
        last_strobe = -1;
        run(3, PAT_ALT, 512, 0, 1'b0, 1'b0);
        drain();
        check("sb_empty_post_rst", sb.size(), 0);

        do_reset();
        run(20, PAT_LOOP, 300, 0, 1'b1, 1'b0);
        drain();
        check("sb_empty_loop", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
